// File: rtl/wb_pkg.sv
// Shared constants and the queued write-back entry type for the writeback arbiter.
package wb_pkg;

  localparam int DATA_WIDTH     = 32;
  localparam int REG_ADDR_WIDTH = 5;
  localparam int REG_COUNT      = 32;

  typedef struct packed {
    logic [REG_ADDR_WIDTH-1:0] rd;
    logic [DATA_WIDTH-1:0]     data;
  } wb_entry_t;

endpackage

// File: rtl/wb_queue.sv
// Synchronous in-order FIFO of long-latency write-back entries.
// The caller never pushes when full nor pops when empty; count is registered.
module wb_queue
  import wb_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  wb_entry_t        push_entry,
  input  logic             pop,
  output wb_entry_t        pop_entry,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

  wb_entry_t        mem_q [DEPTH];
  wb_entry_t        mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_entry;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointers wrap for free because DEPTH is a power of two.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end

  assign pop_entry = mem_q[rd_ptr_q];
  assign full      = (count_q == FULL_COUNT);
  assign empty     = (count_q == '0);
  assign count     = count_q;

endmodule

// File: rtl/writeback_arbiter.sv
// Register-file write-port arbiter: ALU results win, long-latency results drain
// through wb_queue, and a pending-destination scoreboard feeds decode stalls.
// Optional WB_STALL_COUNT_EN adds a saturating stall_cycles counter output.
module writeback_arbiter
  import wb_pkg::*;
#(
  parameter int DATA_WIDTH     = wb_pkg::DATA_WIDTH,
  parameter int REG_ADDR_WIDTH = wb_pkg::REG_ADDR_WIDTH,
  parameter int QUEUE_DEPTH    = 4
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      alu_valid,
  input  logic [REG_ADDR_WIDTH-1:0] alu_rd,
  input  logic [DATA_WIDTH-1:0]     alu_data,
  input  logic                      mem_valid,
  output logic                      mem_ready,
  input  logic [REG_ADDR_WIDTH-1:0] mem_rd,
  input  logic [DATA_WIDTH-1:0]     mem_data,
  input  logic                      issue_valid,
  input  logic [REG_ADDR_WIDTH-1:0] issue_rd,
  output logic [REG_COUNT-1:0]      pending_mask,
  output logic [REG_ADDR_WIDTH-1:0] rd,
  output logic [DATA_WIDTH-1:0]     writeData,
  output logic                      registerWrite
`ifdef WB_STALL_COUNT_EN
  ,
  output logic [31:0]               stall_cycles
`endif
);

  localparam int               CNT_W      = $clog2(QUEUE_DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(QUEUE_DEPTH);

  wb_entry_t        push_entry;
  wb_entry_t        head_entry;
  logic             queue_push;
  logic             queue_pop;
  logic             queue_full;
  logic             queue_empty;
  logic [CNT_W-1:0] queue_count;

  logic alu_commit;
  logic mem_accept;

  logic [REG_ADDR_WIDTH-1:0] rd_q, rd_d;
  logic [DATA_WIDTH-1:0]     write_data_q, write_data_d;
  logic                      register_write_q, register_write_d;
  logic [REG_COUNT-1:0]      pending_q, pending_d;
  logic [REG_COUNT-1:0]      set_mask, clear_mask;

  // Ready looks only at the registered count, so a pop never frees a slot
  // for a push in the same cycle.
  assign mem_ready  = (queue_count != FULL_COUNT) && !reset;
  assign mem_accept = mem_valid && mem_ready;
  assign alu_commit = alu_valid && (alu_rd != '0);

  // Beats to x0 are swallowed on acceptance; they never occupy a slot.
  assign queue_push      = mem_accept && (mem_rd != '0);
  assign queue_pop       = !alu_commit && !queue_empty;
  assign push_entry.rd   = mem_rd;
  assign push_entry.data = mem_data;

  wb_queue #(
    .DEPTH (QUEUE_DEPTH)
  ) u_queue (
    .clock      (clock),
    .reset      (reset),
    .push       (queue_push),
    .push_entry (push_entry),
    .pop        (queue_pop),
    .pop_entry  (head_entry),
    .full       (queue_full),
    .empty      (queue_empty),
    .count      (queue_count)
  );

  always_comb begin
    rd_d             = '0;
    write_data_d     = '0;
    register_write_d = 1'b0;
    if (alu_commit) begin
      rd_d             = alu_rd;
      write_data_d     = alu_data;
      register_write_d = 1'b1;
    end else if (queue_pop) begin
      rd_d             = head_entry.rd;
      write_data_d     = head_entry.data;
      register_write_d = 1'b1;
    end
  end

  // Clear lands on the same edge as the registered write; a same-cycle
  // re-issue of that register overrides the clear.
  always_comb begin
    set_mask   = '0;
    clear_mask = '0;
    if (issue_valid && (issue_rd != '0)) begin
      set_mask[issue_rd] = 1'b1;
    end
    if (queue_pop) begin
      clear_mask[head_entry.rd] = 1'b1;
    end
    pending_d    = (pending_q & ~clear_mask) | set_mask;
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_q             <= '0;
      write_data_q     <= '0;
      register_write_q <= 1'b0;
      pending_q        <= '0;
    end else begin
      rd_q             <= rd_d;
      write_data_q     <= write_data_d;
      register_write_q <= register_write_d;
      pending_q        <= pending_d;
    end
  end

  assign rd            = rd_q;
  assign writeData     = write_data_q;
  assign registerWrite = register_write_q;
  assign pending_mask  = pending_q;

`ifdef WB_STALL_COUNT_EN
  logic [31:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (mem_valid && !mem_ready && (stall_q != '1)) begin
      stall_d = stall_q + 32'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cycles = stall_q;
`endif

  // Decode must never let an ALU result overtake an outstanding long-latency write.
  alu_targets_pending: assert property (@(posedge clock) disable iff (reset)
    !(alu_valid && (alu_rd != '0) && pending_q[alu_rd]));

  no_push_when_full: assert property (@(posedge clock) disable iff (reset)
    !(queue_push && queue_full));

endmodule

// File: tb/tb_writeback_arbiter.sv
// Scoreboard bench for writeback_arbiter: a queue-based reference model predicts
// each cycle's write, pending mask and ready; a monitor checks the write port.
module tb_writeback_arbiter;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int DEPTH = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic          alu_valid;
  logic [AW-1:0] alu_rd;
  logic [DW-1:0] alu_data;
  logic          mem_valid;
  logic          mem_ready;
  logic [AW-1:0] mem_rd;
  logic [DW-1:0] mem_data;
  logic          issue_valid;
  logic [AW-1:0] issue_rd;
  logic [31:0]   pending_mask;
  logic [AW-1:0] rd;
  logic [DW-1:0] writeData;
  logic          registerWrite;
`ifdef WB_STALL_COUNT_EN
  logic [31:0]   stall_cycles;
`endif

  writeback_arbiter #(
    .DATA_WIDTH     (DW),
    .REG_ADDR_WIDTH (AW),
    .QUEUE_DEPTH    (DEPTH)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .alu_valid     (alu_valid),
    .alu_rd        (alu_rd),
    .alu_data      (alu_data),
    .mem_valid     (mem_valid),
    .mem_ready     (mem_ready),
    .mem_rd        (mem_rd),
    .mem_data      (mem_data),
    .issue_valid   (issue_valid),
    .issue_rd      (issue_rd),
    .pending_mask  (pending_mask),
    .rd            (rd),
    .writeData     (writeData),
    .registerWrite (registerWrite)
`ifdef WB_STALL_COUNT_EN
    ,
    .stall_cycles  (stall_cycles)
`endif
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [AW-1:0] rd;
    logic [DW-1:0] data;
  } entry_t;

  typedef struct {
    bit            valid;
    logic [AW-1:0] rd;
    logic [DW-1:0] data;
  } exp_t;

  entry_t      model_queue[$];
  exp_t        expected_q[$];
  logic [31:0] model_pending = '0;
  logic [31:0] model_stall   = '0;
  bit          started       = 1'b0;
  int          tests_run     = 0;
  int          tests_failed  = 0;

  // Reference model: one call per clock edge, using the inputs about to be sampled.
  task automatic modelEdge();
    exp_t        e;
    entry_t      ent;
    bit          ready;
    logic [31:0] clr;
    logic [31:0] setm;
    e.valid = 1'b0;
    e.rd    = '0;
    e.data  = '0;
    if (reset) begin
      model_queue.delete();
      model_pending = '0;
      model_stall   = '0;
    end else begin
      ready = (model_queue.size() < DEPTH);
      if (mem_valid && !ready && model_stall != 32'hFFFF_FFFF) model_stall = model_stall + 1;
      clr  = '0;
      setm = '0;
      if (alu_valid && alu_rd != 0) begin
        e.valid = 1'b1;
        e.rd    = alu_rd;
        e.data  = alu_data;
      end else if (model_queue.size() > 0) begin
        ent       = model_queue.pop_front();
        e.valid   = 1'b1;
        e.rd      = ent.rd;
        e.data    = ent.data;
        clr[ent.rd] = 1'b1;
      end
      if (mem_valid && ready && mem_rd != 0) begin
        ent.rd   = mem_rd;
        ent.data = mem_data;
        model_queue.push_back(ent);
      end
      if (issue_valid && issue_rd != 0) setm[issue_rd] = 1'b1;
      model_pending = (model_pending & ~clr) | setm;
    end
    expected_q.push_back(e);
  endtask

  task automatic checkOutput();
    logic exp_ready;
    if (!started) return;
    exp_ready = (reset === 1'b0) && (model_queue.size() < DEPTH);
    tests_run++;
    if (pending_mask !== model_pending) begin
      tests_failed++;
      $display("[TB] FAIL pending_mask: got %h expected %h at %0t", pending_mask, model_pending, $time);
    end
    tests_run++;
    if (mem_ready !== exp_ready) begin
      tests_failed++;
      $display("[TB] FAIL mem_ready: got %b expected %b at %0t", mem_ready, exp_ready, $time);
    end
`ifdef WB_STALL_COUNT_EN
    tests_run++;
    if (stall_cycles !== model_stall) begin
      tests_failed++;
      $display("[TB] FAIL stall_cycles: got %0d expected %0d at %0t", stall_cycles, model_stall, $time);
    end
`endif
  endtask

  task automatic applyStimulus(input logic rst, input logic av, input logic [AW-1:0] ard,
                               input logic [DW-1:0] ad, input logic mv, input logic [AW-1:0] mrd,
                               input logic [DW-1:0] md, input logic iv, input logic [AW-1:0] ird);
    @(negedge clock);
    checkOutput();
    reset       = rst;
    alu_valid   = av;
    alu_rd      = ard;
    alu_data    = ad;
    mem_valid   = mv;
    mem_rd      = mrd;
    mem_data    = md;
    issue_valid = iv;
    issue_rd    = ird;
    modelEdge();
    started = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: each edge produces exactly one predicted write-port state.
  always @(posedge clock) begin
    exp_t e;
    #1;
    if (expected_q.size() > 0) begin
      e = expected_q.pop_front();
      tests_run++;
      if (registerWrite !== e.valid) begin
        tests_failed++;
        $display("[TB] FAIL registerWrite: got %b expected %b at %0t", registerWrite, e.valid, $time);
      end else if (e.valid) begin
        tests_run++;
        if (rd !== e.rd || writeData !== e.data) begin
          tests_failed++;
          $display("[TB] FAIL write_entry: got rd=%0d data=%h expected rd=%0d data=%h at %0t",
                   rd, writeData, e.rd, e.data, $time);
        end
      end
    end
  end

  initial begin
    logic [AW-1:0] ard;
    reset = 1'b1; alu_valid = 0; alu_rd = 0; alu_data = 0; mem_valid = 0;
    mem_rd = 0; mem_data = 0; issue_valid = 0; issue_rd = 0;

    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);

    // Single ALU write
    applyStimulus(0, 1, 5, 32'h1234, 0, 0, 0, 0, 0);
    idle(2);

    // Issue then long-latency return to x7
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 7);
    applyStimulus(0, 0, 0, 0, 1, 7, 32'hDEAD, 0, 0);
    idle(3);

    // Fill the queue while the ALU owns the port, then drain
    for (int i = 0; i < 4; i++)
      applyStimulus(0, 1, AW'(i + 1), DW'(32'hA000 + i), 1, AW'(i + 10), DW'(32'hB000 + i), 0, 0);
    applyStimulus(0, 1, 6, 32'hA100, 1, 20, 32'hBBBB, 0, 0);
    idle(6);

    // x0 traffic is a no-op
    applyStimulus(0, 1, 0, 32'h5555, 1, 0, 32'h6666, 1, 0);
    applyStimulus(0, 1, 0, 32'h7777, 0, 0, 0, 0, 0);
    idle(2);

    // Re-issue of x9 on the cycle its queued write commits
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 9);
    applyStimulus(0, 0, 0, 0, 1, 9, 32'h9999, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 9);
    idle(2);

    // Reset with entries queued and scoreboard bits set
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 3);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 4);
    applyStimulus(0, 1, 1, 32'hC001, 1, 3, 32'hD003, 1, 6);
    applyStimulus(0, 1, 2, 32'hC002, 1, 4, 32'hD004, 0, 0);
    applyStimulus(0, 1, 5, 32'hC005, 1, 6, 32'hD006, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 2, 32'hC0DE, 0, 0, 0, 0, 0);
    idle(2);

    // Randomized traffic honouring the decode stall contract
    for (int i = 0; i < 1500; i++) begin
      ard = AW'($urandom_range(0, 31));
      while (ard != 0 && model_pending[ard]) ard = AW'($urandom_range(0, 31));
      applyStimulus(($urandom_range(0, 99) == 0),
                    ($urandom_range(0, 99) < 55), ard, $urandom(),
                    ($urandom_range(0, 99) < 60), AW'($urandom_range(0, 31)), $urandom(),
                    ($urandom_range(0, 99) < 40), AW'($urandom_range(0, 31)));
    end
    idle(8);

    @(negedge clock);
    checkOutput();
    @(posedge clock);
    #2;
    tests_run++;
    if (expected_q.size() != 0) begin
      tests_failed++;
      $display("[TB] FAIL scoreboard_drain: got %0d leftover entries expected 0", expected_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
